// File: rtl/display_pkg.sv
// Shared constants for the multiplexed 7-segment display: segment bit order,
// the active-high hex glyph table and a clog2 helper for counter widths.
package display_pkg;

  // Segment bit order on the 7-bit bus: {g,f,e,d,c,b,a} = [6:0]
  localparam int SEG_A = 0;
  localparam int SEG_G = 6;

  // Active-high glyphs, indexed by nibble (entry 0 is the rightmost slice)
  localparam logic [15:0][SEG_G:SEG_A] HEX_A_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Smallest r such that 2**r >= valor
  function automatic int clog2(input int valor);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < valor) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/deco_hex_7seg.sv
// Combinational hex nibble to active-high 7-segment pattern.
// Output polarity is applied by the instantiating module.
module deco_hex_7seg
  import display_pkg::*;
(
  input  logic [3:0]         nibble_i,
  output logic [SEG_G:SEG_A] seg_o
);

  // Straight table lookup, full 0-F coverage
  always_comb begin
    seg_o = HEX_A_SEG[nibble_i];
  end

endmodule

// File: rtl/display_7seg_multiplexado.sv
// Multiplexed 7-segment controller: prescaler, phase/digit scan counters,
// frame-synchronous shadow register, leading-zero blanking and PWM brightness
// with a dark guard phase at the start of every digit slot.
//
// Load handshake: i_Carga is a one-cycle strobe with no ready/back-pressure;
// every cycle it is high captures the data inputs into the pending copy (last
// strobe wins). The pending copy moves to the active copy only at the frame
// boundary; a strobe on the boundary cycle itself goes straight to active.
module display_7seg_multiplexado
  import display_pkg::*;
#(
  parameter int NUM_DIGITOS       = 8,
  parameter int CLK_HZ            = 100_000_000,
  parameter int REFRESCO_HZ       = 1000,
  parameter int BRILLO_BITS       = 4,
  parameter int ANODO_ACTIVO_BAJO = 1,
  parameter int SEG_ACTIVO_BAJO   = 1
) (
  input  logic                     i_Reloj,
  input  logic                     i_Reset,
  input  logic [4*NUM_DIGITOS-1:0] i_Datos,
  input  logic [NUM_DIGITOS-1:0]   i_Puntos,
  input  logic [NUM_DIGITOS-1:0]   i_Habilita,
  input  logic                     i_Ceros_Izq,
  input  logic                     i_Carga,
  input  logic [BRILLO_BITS-1:0]   i_Brillo,
  output logic [6:0]               o_Segmentos,
  output logic                     o_Punto,
  output logic [NUM_DIGITOS-1:0]   o_Anodos,
  output logic                     o_Fin_Trama
);

  localparam int FASES     = 2 ** BRILLO_BITS;
  localparam int DIV_BRUTO = CLK_HZ / (REFRESCO_HZ * NUM_DIGITOS * FASES);
  localparam int DIV       = (DIV_BRUTO < 1) ? 1 : DIV_BRUTO;
  localparam int PW        = (clog2(DIV) < 1) ? 1 : clog2(DIV);
  localparam int DW        = (clog2(NUM_DIGITOS) < 1) ? 1 : clog2(NUM_DIGITOS);
  localparam int FW        = BRILLO_BITS;

  localparam logic [NUM_DIGITOS-1:0] AN_INACTIVO =
    (ANODO_ACTIVO_BAJO != 0) ? {NUM_DIGITOS{1'b1}} : {NUM_DIGITOS{1'b0}};
  localparam logic [6:0] SEG_INACTIVO = (SEG_ACTIVO_BAJO != 0) ? 7'h7F : 7'h00;
  localparam logic       PT_INACTIVO  = (SEG_ACTIVO_BAJO != 0) ? 1'b1 : 1'b0;

  // Scan counters
  logic [PW-1:0] presc_q, presc_d;
  logic [FW-1:0] fase_q, fase_d;
  logic [DW-1:0] dig_q, dig_d;
  logic          tick, fase_wrap, dig_ultimo, frontera;

  // Pending and active copies of the display contents
  logic [4*NUM_DIGITOS-1:0] pend_datos_q, pend_datos_d, act_datos_q, act_datos_d;
  logic [NUM_DIGITOS-1:0]   pend_puntos_q, pend_puntos_d, act_puntos_q, act_puntos_d;
  logic [NUM_DIGITOS-1:0]   pend_hab_q, pend_hab_d, act_hab_q, act_hab_d;
  logic                     pend_ceros_q, pend_ceros_d, act_ceros_q, act_ceros_d;
  logic                     pend_valid_q, pend_valid_d;

  // Registered outputs
  logic [NUM_DIGITOS-1:0] an_q, an_d;
  logic [6:0]             seg_q, seg_d;
  logic                   pt_q, pt_d, fin_q, fin_d;

  // Per-slot selection
  logic [NUM_DIGITOS-1:0] blanco, sel_1hot, an_alto;
  logic                   ceros_arriba;
  logic [3:0]             nib_sel;
  logic                   pt_sel, en_sel, bl_sel, visible, encendido;
  logic [6:0]             seg_alto, seg_act;
  logic                   pt_act;

  deco_hex_7seg u_deco (
    .nibble_i (nib_sel),
    .seg_o    (seg_alto)
  );

  // Prescaler tick, phase counter and digit counter; the boundary is the
  // cycle where both phase and digit wrap back to zero
  always_comb begin
    tick       = (presc_q == PW'(DIV - 1));
    fase_wrap  = tick && (fase_q == {FW{1'b1}});
    dig_ultimo = (dig_q == DW'(NUM_DIGITOS - 1));
    frontera   = fase_wrap && dig_ultimo;
    presc_d    = tick ? '0 : presc_q + PW'(1);
    fase_d     = tick ? fase_q + FW'(1) : fase_q;
    dig_d      = dig_q;
    if (fase_wrap) begin
      dig_d = dig_ultimo ? '0 : dig_q + DW'(1);
    end
  end

  // Shadow register: strobes fill the pending copy, the boundary promotes it
  always_comb begin
    pend_datos_d  = pend_datos_q;
    pend_puntos_d = pend_puntos_q;
    pend_hab_d    = pend_hab_q;
    pend_ceros_d  = pend_ceros_q;
    pend_valid_d  = pend_valid_q;
    act_datos_d   = act_datos_q;
    act_puntos_d  = act_puntos_q;
    act_hab_d     = act_hab_q;
    act_ceros_d   = act_ceros_q;
    if (frontera) begin
      pend_valid_d = 1'b0;
      if (i_Carga) begin
        act_datos_d  = i_Datos;
        act_puntos_d = i_Puntos;
        act_hab_d    = i_Habilita;
        act_ceros_d  = i_Ceros_Izq;
      end else if (pend_valid_q) begin
        act_datos_d  = pend_datos_q;
        act_puntos_d = pend_puntos_q;
        act_hab_d    = pend_hab_q;
        act_ceros_d  = pend_ceros_q;
      end
    end else if (i_Carga) begin
      pend_datos_d  = i_Datos;
      pend_puntos_d = i_Puntos;
      pend_hab_d    = i_Habilita;
      pend_ceros_d  = i_Ceros_Izq;
      pend_valid_d  = 1'b1;
    end
  end

  // Leading-zero blanking: scan from the most significant digit down while
  // every digit so far is a zero without its point; digit 0 always shows
  always_comb begin
    blanco       = '0;
    ceros_arriba = 1'b1;
    for (int k = NUM_DIGITOS - 1; k >= 1; k--) begin
      ceros_arriba = ceros_arriba & (act_datos_q[4*k +: 4] == 4'h0) & ~act_puntos_q[k];
      blanco[k]    = act_ceros_q & ceros_arriba;
    end
  end

  // Pick the nibble, point, enable and blank flag of the digit being scanned
  always_comb begin
    nib_sel  = 4'h0;
    pt_sel   = 1'b0;
    en_sel   = 1'b0;
    bl_sel   = 1'b0;
    sel_1hot = '0;
    for (int k = 0; k < NUM_DIGITOS; k++) begin
      if (dig_q == DW'(k)) begin
        nib_sel     = act_datos_q[4*k +: 4];
        pt_sel      = act_puntos_q[k];
        en_sel      = act_hab_q[k];
        bl_sel      = blanco[k];
        sel_1hot[k] = 1'b1;
      end
    end
  end

  // Output next-state: anode lit in phases 1..i_Brillo, segments only
  // refreshed during the guard phase so they never change under a lit anode
  always_comb begin
    visible   = en_sel & ~bl_sel;
    encendido = (fase_q != '0) && (fase_q <= i_Brillo) && visible;
    an_alto   = encendido ? sel_1hot : '0;
    an_d      = (ANODO_ACTIVO_BAJO != 0) ? ~an_alto : an_alto;
    seg_act   = visible ? seg_alto : 7'h00;
    pt_act    = visible & pt_sel;
    seg_d     = seg_q;
    pt_d      = pt_q;
    if (fase_q == '0) begin
      seg_d = (SEG_ACTIVO_BAJO != 0) ? ~seg_act : seg_act;
      pt_d  = (SEG_ACTIVO_BAJO != 0) ? ~pt_act : pt_act;
    end
    fin_d = frontera;
  end

  // State and output registers; reset aborts the scan and darkens the display
  always_ff @(posedge i_Reloj or posedge i_Reset) begin
    if (i_Reset) begin
      presc_q       <= '0;
      fase_q        <= '0;
      dig_q         <= '0;
      pend_datos_q  <= '0;
      pend_puntos_q <= '0;
      pend_hab_q    <= '0;
      pend_ceros_q  <= 1'b0;
      pend_valid_q  <= 1'b0;
      act_datos_q   <= '0;
      act_puntos_q  <= '0;
      act_hab_q     <= '0;
      act_ceros_q   <= 1'b0;
      an_q          <= AN_INACTIVO;
      seg_q         <= SEG_INACTIVO;
      pt_q          <= PT_INACTIVO;
      fin_q         <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      fase_q        <= fase_d;
      dig_q         <= dig_d;
      pend_datos_q  <= pend_datos_d;
      pend_puntos_q <= pend_puntos_d;
      pend_hab_q    <= pend_hab_d;
      pend_ceros_q  <= pend_ceros_d;
      pend_valid_q  <= pend_valid_d;
      act_datos_q   <= act_datos_d;
      act_puntos_q  <= act_puntos_d;
      act_hab_q     <= act_hab_d;
      act_ceros_q   <= act_ceros_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      pt_q          <= pt_d;
      fin_q         <= fin_d;
    end
  end

  assign o_Anodos    = an_q;
  assign o_Segmentos = seg_q;
  assign o_Punto     = pt_q;
  assign o_Fin_Trama = fin_q;

endmodule

// File: tb/tb_display_7seg_multiplexado.sv
// Bench for display_7seg_multiplexado with 4 digits, DIV = 10 (slot 40 cycles,
// frame 160 cycles), active-low anodes and segments. Each observed frame is
// summarised per slot as {lit cycles, glyph, point} and matched against
// hand-computed frames queued by the stimulus.
module tb_display_7seg_multiplexado;

  localparam int ND    = 4;
  localparam int SLOT  = 40;
  localparam int FRAME = 160;
  localparam int W     = 4 * 14;

  // Active-low glyphs, hand-derived from the {g,f,e,d,c,b,a} bit order
  localparam logic [6:0] G0 = 7'h40;
  localparam logic [6:0] G1 = 7'h79;
  localparam logic [6:0] G2 = 7'h24;
  localparam logic [6:0] G3 = 7'h30;
  localparam logic [6:0] G4 = 7'h19;
  localparam logic [6:0] G5 = 7'h12;
  localparam logic [6:0] GB = 7'h03;
  localparam logic [13:0] DARK = {6'd0, 7'h7F, 1'b1};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] datos   = '0;
  logic [3:0]  puntos  = '0;
  logic [3:0]  hab     = '0;
  logic        ceros   = 1'b0;
  logic        carga   = 1'b0;
  logic [1:0]  brillo  = '0;
  logic [6:0]  seg;
  logic        punto;
  logic [3:0]  anodos;
  logic        fin;

  display_7seg_multiplexado #(
    .NUM_DIGITOS       (ND),
    .CLK_HZ            (1600),
    .REFRESCO_HZ       (10),
    .BRILLO_BITS       (2),
    .ANODO_ACTIVO_BAJO (1),
    .SEG_ACTIVO_BAJO   (1)
  ) dut (
    .i_Reloj     (clk),
    .i_Reset     (rst),
    .i_Datos     (datos),
    .i_Puntos    (puntos),
    .i_Habilita  (hab),
    .i_Ceros_Izq (ceros),
    .i_Carga     (carga),
    .i_Brillo    (brillo),
    .o_Segmentos (seg),
    .o_Punto     (punto),
    .o_Anodos    (anodos),
    .o_Fin_Trama (fin)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           exp_tag_q[$];
  int           checks   = 0;
  int           errors   = 0;
  int           win_idx  = -1;
  int           last_tag = -1;

  function automatic logic [13:0] mk_slot(input int cnt, input logic [6:0] s, input logic p);
    return {6'(cnt), s, p};
  endfunction

  function automatic logic [W-1:0] mk_frame(input logic [13:0] s3, input logic [13:0] s2,
                                            input logic [13:0] s1, input logic [13:0] s0);
    return {s3, s2, s1, s0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic push(input int tag, input logic [W-1:0] f);
    exp_q.push_back(f);
    exp_tag_q.push_back(tag);
    if (tag > last_tag) last_tag = tag;
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    bit           in_fin;
    bit           aborted;
    bit           stray;
    int           w;
    int           slot;
    int           cnt [ND];
    logic [6:0]   sg [ND];
    logic         pt [ND];
    logic [6:0]   s0;
    logic         p0;
    logic [W-1:0] obs;
    logic [W-1:0] expf;
    in_fin = 1'b0;
    forever begin
      if (!in_fin) begin
        @(negedge clk);
        in_fin = fin && !rst;
      end else begin
        win_idx++;
        w       = win_idx;
        aborted = 1'b0;
        stray   = 1'b0;
        s0      = '0;
        p0      = 1'b0;
        for (int k = 0; k < ND; k++) begin
          cnt[k] = 0;
          sg[k]  = '0;
          pt[k]  = 1'b0;
        end
        for (int c = 0; c < FRAME; c++) begin
          @(negedge clk);
          if (rst) aborted = 1'b1;
          if (!aborted) begin
            slot = c / SLOT;
            for (int k = 0; k < ND; k++) begin
              if (!anodos[k]) begin
                if (k == slot) cnt[k]++;
                else stray = 1'b1;
              end
            end
            if (c % SLOT == 0) begin
              s0 = seg;
              p0 = punto;
            end else if (seg !== s0 || punto !== p0) begin
              stray = 1'b1;
            end
            if (c % SLOT == SLOT - 1) begin
              sg[slot] = seg;
              pt[slot] = punto;
            end
            if (c < FRAME - 1 && fin) stray = 1'b1;
          end
        end
        if (aborted) begin
          in_fin = 1'b0;
        end else begin
          in_fin = fin;
          check($sformatf("frame_len_%0d", w), 64'(fin), 64'(1));
          check($sformatf("scan_rules_%0d", w), 64'(stray), 64'(0));
          while (exp_tag_q.size() > 0 && exp_tag_q[0] < w) begin
            checks++;
            errors++;
            $display("FAIL missed_frame_%0d: expectation never observed", exp_tag_q[0]);
            void'(exp_q.pop_front());
            void'(exp_tag_q.pop_front());
          end
          if (exp_tag_q.size() > 0 && exp_tag_q[0] == w) begin
            expf = exp_q.pop_front();
            void'(exp_tag_q.pop_front());
            obs = mk_frame(mk_slot(cnt[3], sg[3], pt[3]), mk_slot(cnt[2], sg[2], pt[2]),
                           mk_slot(cnt[1], sg[1], pt[1]), mk_slot(cnt[0], sg[0], pt[0]));
            check($sformatf("frame_%0d", w), 64'(obs), 64'(expf));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_fin(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (fin) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL fin_timeout: got no o_Fin_Trama within 400 cycles, required one");
    end
  endtask

  task automatic count_to_fin(output int n);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n++;
      if (fin) break;
    end
  endtask

  // Returns at cycle 0 of a fresh window, with its index
  task automatic sync_window(output int w);
    bit ok;
    wait_fin(ok);
    @(negedge clk);
    w = win_idx;
  endtask

  // First window that has no expectation queued yet
  task automatic sync_after(output int w);
    sync_window(w);
    for (int i = 0; i < 8 && w <= last_tag; i++) sync_window(w);
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] h,
                      input logic z);
    datos  = d;
    puntos = p;
    hab    = h;
    ceros  = z;
    carga  = 1'b1;
    @(negedge clk);
    carga  = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stimulus
    int w;
    int n;
    logic [W-1:0] f1234;
    logic [W-1:0] f_0050p;
    f1234   = mk_frame(mk_slot(30, G1, 1'b1), mk_slot(30, G2, 1'b1),
                       mk_slot(30, G3, 1'b1), mk_slot(30, G4, 1'b1));
    f_0050p = mk_frame(DARK, mk_slot(30, G0, 1'b0),
                       mk_slot(30, G5, 1'b1), mk_slot(30, G0, 1'b1));
    brillo = 2'd3;

    // Reset for 20 cycles, then idle: dark display, frame strobe every 160
    repeat (20) @(negedge clk);
    check("reset_anodes", 64'(anodos), 64'(4'hF));
    check("reset_segments", 64'(seg), 64'(7'h7F));
    check("reset_point", 64'(punto), 64'(1'b1));
    check("reset_fin", 64'(fin), 64'(1'b0));
    rst = 1'b0;
    count_to_fin(n);
    check("first_fin_cycles", 64'(n), 64'(FRAME));
    @(negedge clk);
    w = win_idx;
    push(w, mk_frame(DARK, DARK, DARK, DARK));
    push(w + 1, mk_frame(DARK, DARK, DARK, DARK));

    // 1234 at full brightness, visible from the frame after the load
    sync_after(w);
    repeat (20) @(negedge clk);
    load(16'h1234, 4'h0, 4'hF, 1'b0);
    push(w + 1, f1234);

    // Live brightness changes at window starts: 0, then 1, then back to 3
    sync_after(w);
    brillo = 2'd0;
    push(w, mk_frame(mk_slot(0, G1, 1'b1), mk_slot(0, G2, 1'b1),
                     mk_slot(0, G3, 1'b1), mk_slot(0, G4, 1'b1)));
    sync_after(w);
    brillo = 2'd1;
    push(w, mk_frame(mk_slot(10, G1, 1'b1), mk_slot(10, G2, 1'b1),
                     mk_slot(10, G3, 1'b1), mk_slot(10, G4, 1'b1)));
    sync_after(w);
    brillo = 2'd3;
    push(w, f1234);

    // Leading-zero blanking of 0050, then with the point on digit 2
    sync_after(w);
    repeat (20) @(negedge clk);
    load(16'h0050, 4'h0, 4'hF, 1'b1);
    push(w + 1, mk_frame(DARK, DARK, mk_slot(30, G5, 1'b1), mk_slot(30, G0, 1'b1)));
    sync_after(w);
    repeat (20) @(negedge clk);
    load(16'h0050, 4'b0100, 4'hF, 1'b1);
    push(w + 1, f_0050p);

    // Two loads in one frame: old value held, then only the last one shows
    sync_after(w);
    push(w, f_0050p);
    repeat (20) @(negedge clk);
    load(16'hAAAA, 4'h0, 4'hF, 1'b0);
    repeat (60) @(negedge clk);
    load(16'hBBBB, 4'h0, 4'hF, 1'b0);
    push(w + 1, mk_frame(mk_slot(30, GB, 1'b1), mk_slot(30, GB, 1'b1),
                         mk_slot(30, GB, 1'b1), mk_slot(30, GB, 1'b1)));
    push(w + 2, mk_frame(mk_slot(30, GB, 1'b1), mk_slot(30, GB, 1'b1),
                         mk_slot(30, GB, 1'b1), mk_slot(30, GB, 1'b1)));

    // Asynchronous reset at cycle 70 of a lit frame (digit 1 slot, phase 3)
    sync_after(w);
    repeat (70) @(negedge clk);
    check("pre_reset_anodes", 64'(anodos), 64'(4'b1101));
    rst = 1'b1;
    #1;
    check("async_reset_anodes", 64'(anodos), 64'(4'hF));
    check("async_reset_segments", 64'(seg), 64'(7'h7F));
    check("async_reset_point", 64'(punto), 64'(1'b1));
    check("async_reset_fin", 64'(fin), 64'(1'b0));
    repeat (5) @(negedge clk);
    rst = 1'b0;
    count_to_fin(n);
    check("restart_fin_cycles", 64'(n), 64'(FRAME));
    @(negedge clk);
    w = win_idx;
    push(w, mk_frame(DARK, DARK, DARK, DARK));

    // Per-digit enables: points and glyphs only on enabled digits 0 and 2
    repeat (20) @(negedge clk);
    load(16'h0000, 4'hF, 4'b0101, 1'b0);
    push(w + 1, mk_frame(DARK, mk_slot(30, G0, 1'b0), DARK, mk_slot(30, G0, 1'b0)));

    sync_after(w);
    repeat (2) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
